// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, SRAM request, 2-entry
// PC-tagged instruction buffer feeding decode over valid/ready.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] PC,
    output logic [31:0] Inst,
    output logic        excp_adef,
    output logic        right_valid,
    input  logic        right_ready
);

    logic [31:0] pc_req_q, pc_req_d;
    logic        req_q, req_d;
    logic [31:0] req_pc_q;
    logic        halted_q, halted_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [31:0] buf_pc_q   [2];
    logic [31:0] buf_inst_q [2];
    logic        buf_adef_q [2];

    logic        pop;
    logic        aligned;
    logic [2:0]  used;
    logic        room;
    logic        push_rsp;
    logic        push_adef;
    logic        push;
    logic [31:0] push_pc;
    logic [31:0] push_inst;

    // Handshake, credit check and push selection.
    always_comb begin
        right_valid    = (cnt_q != 2'd0);
        pop            = right_valid & right_ready & ~flush;
        aligned        = (pc_req_q[1:0] == 2'b00);
        // Slots still free once all outstanding responses land.
        used           = {1'b0, cnt_q} + {2'b0, req_q} - {2'b0, pop};
        room           = (used < 3'(BUF_DEPTH));
        inst_sram_en   = ~reset & ~flush & ~halted_q & aligned & room;
        inst_sram_addr = {pc_req_q[31:2], 2'b00};
        push_rsp       = ~reset & ~flush & req_q;
        // A misaligned PC is only reachable right after a flush, so
        // no response is ever in flight alongside it.
        push_adef      = ~reset & ~flush & ~halted_q & ~aligned
                         & room & ~req_q;
        push           = push_rsp | push_adef;
        push_pc        = push_rsp ? req_pc_q : pc_req_q;
        push_inst      = push_rsp ? inst_sram_rdata : 32'h0;
    end

    // Next-state for PC, request tracking, halt and FIFO pointers.
    always_comb begin
        pc_req_d = pc_req_q;
        req_d    = inst_sram_en;
        halted_d = halted_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            pc_req_d = flush_pc;
            req_d    = 1'b0;
            halted_d = 1'b0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (inst_sram_en) pc_req_d = pc_req_q + 32'd4;
            if (push_adef)    halted_d = 1'b1;
            if (push)         wr_ptr_d = ~wr_ptr_q;
            if (pop)          rd_ptr_d = ~rd_ptr_q;
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_req_q <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= 32'h0;
            halted_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            pc_req_q <= pc_req_d;
            req_q    <= req_d;
            req_pc_q <= pc_req_q;
            halted_q <= halted_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Buffer storage; cleared on reset so idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]   <= 32'h0;
                buf_inst_q[i] <= 32'h0;
                buf_adef_q[i] <= 1'b0;
            end
        end else if (push) begin
            buf_pc_q[wr_ptr_q]   <= push_pc;
            buf_inst_q[wr_ptr_q] <= push_inst;
            buf_adef_q[wr_ptr_q] <= push_adef;
        end
    end

    assign PC        = buf_pc_q[rd_ptr_q];
    assign Inst      = buf_inst_q[rd_ptr_q];
    assign excp_adef = buf_adef_q[rd_ptr_q];

    // The credit check must keep a push away from a full buffer.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (reset)
        !(push && cnt_q == 2'd2)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: queue-based reference model, SRAM model,
// directed literal checks followed by randomized traffic.
module tb_if_stage;

    localparam logic [31:0] RST = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] PC;
    logic [31:0] Inst;
    logic        excp_adef;
    logic        right_valid;
    logic        right_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_known = 1'b0;

    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_inst;
    logic        s_adef;
    logic        s_en;
    logic [31:0] s_addr;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .PC              (PC),
        .Inst            (Inst),
        .excp_adef       (excp_adef),
        .right_valid     (right_valid),
        .right_ready     (right_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a1234;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // One clock cycle: compare mid-cycle, then advance model and SRAM.
    task automatic step();
        bit pop;
        bit en;
        int used;
        pop  = 1'b0;
        en   = 1'b0;
        used = 0;
        #3;
        s_valid = right_valid;
        s_pc    = PC;
        s_inst  = Inst;
        s_adef  = excp_adef;
        s_en    = inst_sram_en;
        s_addr  = inst_sram_addr;
        if (m_known) begin
            pop  = (mq.size() != 0) && right_ready && !flush;
            used = mq.size() + int'(m_pend) - int'(pop);
            en   = !reset && !flush && !m_halt
                   && (m_pc[1:0] == 2'b00) && (used < 2);
            chk("right_valid", 32'(right_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("PC", PC, mq[0].pc);
                chk("Inst", Inst, mq[0].inst);
                chk("excp_adef", 32'(excp_adef), 32'(mq[0].adef));
            end
            chk("sram_en", 32'(inst_sram_en), 32'(en));
            if (!reset && !flush)
                chk("sram_addr", inst_sram_addr, {m_pc[31:2], 2'b00});
        end
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_pend  = 1'b0;
            m_pc    = RST;
            m_halt  = 1'b0;
            m_known = 1'b1;
        end else if (flush) begin
            mq.delete();
            m_pend = 1'b0;
            m_halt = 1'b0;
            m_pc   = flush_pc;
        end else if (m_known) begin
            if (pop) void'(mq.pop_front());
            if (m_pend)
                mq.push_back('{pc: m_pend_pc, inst: memf(m_pend_pc),
                               adef: 1'b0});
            if (!m_halt && m_pc[1:0] != 2'b00 && used < 2) begin
                mq.push_back('{pc: m_pc, inst: 32'h0, adef: 1'b1});
                m_halt = 1'b1;
            end
            chk("model_depth", 32'(mq.size() <= 2), 32'd1);
            m_pend    = en;
            m_pend_pc = m_pc;
            if (en) m_pc = m_pc + 32'd4;
        end
        #1;
        inst_sram_rdata = s_en ? memf(s_addr) : $urandom();
    endtask

    initial begin
        reset           = 1'b1;
        flush           = 1'b0;
        flush_pc        = 32'h0;
        right_ready     = 1'b1;
        inst_sram_rdata = 32'h0;

        step();
        step();
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_PC", s_pc, 32'h0);
        chk("rst_Inst", s_inst, 32'h0);
        chk("rst_adef", 32'(s_adef), 32'd0);
        chk("rst_en", 32'(s_en), 32'd0);
        chk("rst_addr", s_addr, 32'h1c000000);

        reset = 1'b0;
        step();
        chk("c0_en", 32'(s_en), 32'd1);
        chk("c0_addr", s_addr, 32'h1c000000);
        step();
        step();
        chk("c2_valid", 32'(s_valid), 32'd1);
        chk("c2_PC", s_pc, 32'h1c000000);
        chk("c2_Inst", s_inst, 32'h5a5af1cb);
        step();
        chk("c3_PC", s_pc, 32'h1c000004);

        right_ready = 1'b0;
        repeat (5) step();
        chk("full_en", 32'(s_en), 32'd0);
        chk("full_PC", s_pc, 32'h1c000008);
        right_ready = 1'b1;
        repeat (6) step();

        flush    = 1'b1;
        flush_pc = 32'h1c000102;
        step();
        flush = 1'b0;
        step();
        chk("adef_noreq", 32'(s_en), 32'd0);
        step();
        chk("adef_valid", 32'(s_valid), 32'd1);
        chk("adef_PC", s_pc, 32'h1c000102);
        chk("adef_flag", 32'(s_adef), 32'd1);
        chk("adef_Inst", s_inst, 32'h0);
        repeat (3) step();
        chk("halt_en", 32'(s_en), 32'd0);

        flush    = 1'b1;
        flush_pc = 32'h1c000200;
        step();
        flush = 1'b0;
        step();
        chk("resume_en", 32'(s_en), 32'd1);
        chk("resume_addr", s_addr, 32'h1c000200);
        step();
        step();
        chk("resume_PC", s_pc, 32'h1c000200);
        chk("resume_adef", 32'(s_adef), 32'd0);

        repeat (3000) begin
            reset       = ($urandom_range(0, 99) == 0);
            flush       = !reset && ($urandom_range(0, 29) == 0);
            flush_pc    = RST + (32'($urandom_range(0, 255)) << 2)
                          + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
            right_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
